scrambler_key_ctrl: RTL and testbench
=====================================

Name: scrambler_key_ctrl

Overview:
- Key-gated configuration controller for the scrambler's enable vector. It sits between the IJTAG test-data-register control signals and the scrambler's enable inputs.
- A key is shifted in serially and checked against a compile-time secret.
- Only after a successful unlock may subsequent update operations program the enables.
- Repeated wrong keys cause a sticky lockout that only reset clears.

Parameters:
- KEY_W, 8, width of the key/shift register; must be >= N_EN.
- N_EN, 4, width of the enables vector driven to the scrambler.
- SECRET, 8'hA5, unlock key (KEY_W bits).
- MAX_FAIL, 3, number of consecutive wrong keys that triggers lockout (>= 1).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- capture_en  input  1  parallel-load status into the shift register.
- shift_en  input  1  shift the register by one bit.
- update_en  input  1  commit the shift register contents.
- scan_in  input  1  serial data in.
- scan_out  output  1  serial data out.
- enables  output  N_EN  scrambler enable vector (registered).
- unlocked  output  1  high in the UNLOCKED state.
- locked_out  output  1  high in the LOCKOUT state.

Behaviour:
- Reset (reset=0, asynchronous):
  - sr=0, fail_cnt=0, state=LOCKED.
  - enables=0, unlocked=0, locked_out=0, scan_out=0.
- Control priority, evaluated per cycle when more than one strobe is high: capture_en > shift_en > update_en. Lower-priority strobes are ignored that cycle.
- capture_en: sr <= status word zero-extended to KEY_W. Bits are {fail_cnt, locked_out, unlocked}, with unlocked at sr[0].
- shift_en: sr <= {scan_in, sr[KEY_W-1:1]} (LSB out first).
- scan_out = sr[0] combinationally, except forced to 0 while in LOCKOUT.
- fail_cnt width is clog2(MAX_FAIL+1) and it saturates at MAX_FAIL.
- State machine; all transitions occur on the clk edge where update_en is accepted:
  - LOCKED, update, sr==SECRET: go to UNLOCKED and set fail_cnt=0.
  - LOCKED, update, sr!=SECRET: fail_cnt+1. If the new count == MAX_FAIL go to LOCKOUT, else stay in LOCKED.
  - UNLOCKED, update, sr==~SECRET: relock. Go to LOCKED and clear enables in the same edge.
  - UNLOCKED, any other update: enables <= sr[N_EN-1:0]. The new value is visible the cycle after the update edge (1-cycle latency).
  - LOCKOUT: update ignored and enables held at 0. Capture and shift still operate, but scan_out reads 0. Exit only via reset.
- Outputs in LOCKED and LOCKOUT: enables=0 at all times. The enables register is cleared on entry to either state.
- unlocked and locked_out are registered, decoded from the state, and valid the cycle after the transition edge.
- A successful unlock resets fail_cnt. Failures need not be contiguous across a relock; fail_cnt persists until unlock or reset.
- Reset asserted mid-shift or mid-update aborts the operation immediately and all state returns to reset values. The first edge after deassertion behaves as from reset.
- Strobes sampled while reset is low have no effect.

Test Plan:
- Reset then capture (defaults: KEY_W=8, SECRET=A5, N_EN=4, MAX_FAIL=3): shift 8 bits out -> scan_out sequence is all 0; enables=0, unlocked=0.
- Shift in 8'hA5 (LSB first), update -> unlocked=1 the next cycle. Then shift 8'h06 and update -> enables=4'b0110 one cycle after the update.
- Unlocked: shift 8'h5A (~A5), update -> enables=0 and unlocked=0. Capture then reports sr[0]=0.
- From reset: three updates with key 8'h00 -> after the 3rd, locked_out=1. A 4th update with A5 keeps locked_out=1 and enables=0, and scan_out stays 0 while shifting.
- Two wrong keys then A5 -> unlocked=1, and capture shows fail_cnt=0 (status word 8'h01). A later wrong key after relock leaves fail_cnt=1.
- Simultaneous capture_en=shift_en=update_en=1 with sr=A5 in LOCKED -> capture only; state stays LOCKED. Reset pulsed low mid-shift -> all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/scrambler_key_ctrl.sv
// Key-gated controller for the scrambler enable vector, driven by IJTAG TDR strobes.
// Enables are programmable only after the shifted-in key matches SECRET; repeated misses lock out until reset.
module scrambler_key_ctrl #(
    parameter int unsigned      KEY_W    = 8,
    parameter int unsigned      N_EN     = 4,
    parameter logic [KEY_W-1:0] SECRET   = 8'hA5,
    parameter int unsigned      MAX_FAIL = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            capture_en,
    input  logic            shift_en,
    input  logic            update_en,
    input  logic            scan_in,
    output logic            scan_out,
    output logic [N_EN-1:0] enables,
    output logic            unlocked,
    output logic            locked_out
);

    localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int unsigned STAT_W = FAIL_W + 2;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [KEY_W-1:0]    sr_q;
    logic [FAIL_W-1:0]   fail_q;
    logic [FAIL_W-1:0]   fail_d;
    logic [FAIL_W-1:0]   fail_inc;
    logic [N_EN-1:0]     enables_d;
    logic                unlocked_d;
    logic                locked_out_d;
    logic                upd;
    logic [STAT_W-1:0]   status;

    // update only takes effect when neither higher-priority strobe is active
    assign upd      = update_en && !capture_en && !shift_en;
    assign status   = {fail_q, locked_out, unlocked};
    assign fail_inc = (fail_q == FAIL_W'(MAX_FAIL)) ? fail_q : fail_q + FAIL_W'(1);
    assign scan_out = (state_q == ST_LOCKOUT) ? 1'b0 : sr_q[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_LOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        if (upd) begin
            case (state_q)
                ST_LOCKED: begin
                    if (sr_q == SECRET) begin
                        state_d = ST_UNLOCKED;
                        fail_d  = '0;
                    end else begin
                        fail_d = fail_inc;
                        if (fail_inc == FAIL_W'(MAX_FAIL)) begin
                            state_d = ST_LOCKOUT;
                        end
                    end
                end
                ST_UNLOCKED: begin
                    if (sr_q == ~SECRET) begin
                        state_d = ST_LOCKED;
                    end
                end
                ST_LOCKOUT: begin
                    state_d = ST_LOCKOUT;
                end
                default: begin
                    state_d = ST_LOCKED;
                end
            endcase
        end
    end

    // enables are forced to zero whenever the next state is not UNLOCKED
    always_comb begin
        unlocked_d   = (state_d == ST_UNLOCKED);
        locked_out_d = (state_d == ST_LOCKOUT);
        enables_d    = enables;
        if (state_d != ST_UNLOCKED) begin
            enables_d = '0;
        end else if (upd && (state_q == ST_UNLOCKED)) begin
            enables_d = sr_q[N_EN-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q       <= '0;
            fail_q     <= '0;
            enables    <= '0;
            unlocked   <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            fail_q     <= fail_d;
            enables    <= enables_d;
            unlocked   <= unlocked_d;
            locked_out <= locked_out_d;
            if (capture_en) begin
                sr_q <= KEY_W'(status);
            end else if (shift_en) begin
                sr_q <= {scan_in, sr_q[KEY_W-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_scrambler_key_ctrl.sv
// Bench for scrambler_key_ctrl: abstract integer model checked every cycle plus literal spot checks.
module tb_scrambler_key_ctrl;

    localparam int SECRET = 8'hA5;
    localparam int MAXF   = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       capture_en = 1'b0;
    logic       shift_en   = 1'b0;
    logic       update_en  = 1'b0;
    logic       scan_in    = 1'b0;
    logic       scan_out;
    logic [3:0] enables;
    logic       unlocked;
    logic       locked_out;

    int total = 0;
    int bad   = 0;

    // model: st 0=locked, 1=unlocked, 2=lockout
    int m_sr   = 0;
    int m_fail = 0;
    int m_st   = 0;
    int m_en   = 0;

    scrambler_key_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .capture_en (capture_en),
        .shift_en   (shift_en),
        .update_en  (update_en),
        .scan_in    (scan_in),
        .scan_out   (scan_out),
        .enables    (enables),
        .unlocked   (unlocked),
        .locked_out (locked_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_sr   <= 0;
            m_fail <= 0;
            m_st   <= 0;
            m_en   <= 0;
        end else if (capture_en) begin
            m_sr <= m_fail * 4 + ((m_st == 2) ? 2 : 0) + ((m_st == 1) ? 1 : 0);
        end else if (shift_en) begin
            m_sr <= (m_sr / 2) + (scan_in ? 128 : 0);
        end else if (update_en) begin
            if (m_st == 0) begin
                if (m_sr == SECRET) begin
                    m_st   <= 1;
                    m_fail <= 0;
                end else begin
                    m_fail <= (m_fail + 1 >= MAXF) ? MAXF : m_fail + 1;
                    if (m_fail + 1 >= MAXF) m_st <= 2;
                end
            end else if (m_st == 1) begin
                if (m_sr == 255 - SECRET) begin
                    m_st <= 0;
                    m_en <= 0;
                end else begin
                    m_en <= m_sr % 16;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("scan_out",   int'(scan_out),   (m_st == 2) ? 0 : m_sr % 2);
        check("enables",    int'(enables),    m_en);
        check("unlocked",   int'(unlocked),   (m_st == 1) ? 1 : 0);
        check("locked_out", int'(locked_out), (m_st == 2) ? 1 : 0);
    end

    task automatic strobes_off();
        capture_en = 1'b0;
        shift_en   = 1'b0;
        update_en  = 1'b0;
        scan_in    = 1'b0;
    endtask

    task automatic shift_byte(input logic [7:0] din, output logic [7:0] dout);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            dout[i]  = scan_out;
            strobes_off();
            shift_en = 1'b1;
            scan_in  = din[i];
        end
        @(negedge clk);
        strobes_off();
    endtask

    task automatic do_update();
        @(negedge clk);
        strobes_off();
        update_en = 1'b1;
        @(negedge clk);
        strobes_off();
    endtask

    task automatic do_capture();
        @(negedge clk);
        strobes_off();
        capture_en = 1'b1;
        @(negedge clk);
        strobes_off();
    endtask

    task automatic key_update(input logic [7:0] k);
        logic [7:0] d;
        shift_byte(k, d);
        do_update();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        strobes_off();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] d;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("rst_enables", int'(enables), 0);
        check("rst_unlocked", int'(unlocked), 0);
        check("rst_locked_out", int'(locked_out), 0);
        check("rst_scan_out", int'(scan_out), 0);

        // capture after reset reads all-zero status, then unlock with A5
        do_capture();
        shift_byte(8'hA5, d);
        check("status_after_reset", int'(d), 8'h00);
        do_update();
        check("unlock_a5", int'(unlocked), 1);
        key_update(8'h06);
        check("program_0110", int'(enables), 4'b0110);
        check("still_unlocked", int'(unlocked), 1);

        // relock with ~SECRET
        key_update(8'h5A);
        check("relock_enables", int'(enables), 0);
        check("relock_unlocked", int'(unlocked), 0);
        do_capture();
        shift_byte(8'h00, d);
        check("relock_status_bit0", int'(d[0]), 0);

        // three wrong keys lead to lockout
        apply_reset();
        key_update(8'h00);
        key_update(8'h00);
        check("two_fails_not_lockout", int'(locked_out), 0);
        key_update(8'h00);
        check("lockout_after_3", int'(locked_out), 1);
        shift_byte(8'hA5, d);
        shift_byte(8'h00, d);
        check("lockout_scan_zero", int'(d), 8'h00);
        shift_byte(8'hA5, d);
        do_update();
        check("lockout_sticky", int'(locked_out), 1);
        check("lockout_enables", int'(enables), 0);
        check("lockout_not_unlocked", int'(unlocked), 0);
        do_capture();
        shift_byte(8'h00, d);
        check("lockout_capture_scan", int'(d), 8'h00);

        // unlock resets fail_cnt; a later miss leaves it at 1
        apply_reset();
        key_update(8'h00);
        key_update(8'h11);
        key_update(8'hA5);
        check("unlock_after_2_fails", int'(unlocked), 1);
        do_capture();
        shift_byte(8'h5A, d);
        check("status_unlocked", int'(d), 8'h01);
        do_update();
        check("relock2", int'(unlocked), 0);
        key_update(8'h33);
        check("fail_not_lockout", int'(locked_out), 0);
        do_capture();
        shift_byte(8'h00, d);
        check("status_fail1", int'(d), 8'h04);

        // all strobes together: capture wins
        apply_reset();
        shift_byte(8'hA5, d);
        @(negedge clk);
        capture_en = 1'b1;
        shift_en   = 1'b1;
        update_en  = 1'b1;
        @(negedge clk);
        strobes_off();
        check("simul_stay_locked", int'(unlocked), 0);
        shift_byte(8'h00, d);
        check("simul_captured", int'(d), 8'h00);

        // async reset mid-shift with nonzero outputs
        key_update(8'hA5);
        key_update(8'h0F);
        check("pre_reset_enables", int'(enables), 4'hF);
        key_update(8'hFF);
        @(negedge clk);
        shift_en = 1'b1;
        scan_in  = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_enables", int'(enables), 0);
        check("async_unlocked", int'(unlocked), 0);
        check("async_locked_out", int'(locked_out), 0);
        check("async_scan_out", int'(scan_out), 0);
        @(negedge clk);
        strobes_off();
        reset = 1'b1;
        do_capture();
        shift_byte(8'h00, d);
        check("post_reset_status", int'(d), 8'h00);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
